lock_monitor: RTL



---
 rtl/lock_monitor_pkg.sv | 16 +
 rtl/lock_monitor_debounce.sv | 58 +++++
 rtl/lock_monitor.sv | 139 +++++++++++++
 3 files changed

// File: rtl/lock_monitor_pkg.sv
// Shared register map, readback map and helpers for the lock monitor.
package lock_monitor_pkg;

    localparam int unsigned LM_SR_DB_LIMIT = 0;
    localparam int unsigned LM_SR_LOST_CLR = 1;
    localparam int unsigned LM_SR_CNT_CLR  = 2;
    localparam int unsigned LM_SR_IRQ_EN   = 3;

    localparam int unsigned LM_RB_STATUS   = 0;
    localparam int unsigned LM_RB_CFG      = 1;
    localparam int unsigned LM_RB_RAW      = 2;
    localparam int unsigned LM_RB_CNT_BASE = 8;

    localparam logic [31:0] LM_RB_DEFAULT  = 32'hdeadbeef;

endpackage

// File: rtl/lock_monitor_debounce.sv
// One lock channel: resynchroniser, stability counter, debounced status and
// a one-cycle pulse when the debounced status falls.
module lock_debounce #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_WIDTH    = 16
) (
    input  logic                bus_clk,
    input  logic                bus_rst,
    input  logic                i_lock,
    input  logic [DB_WIDTH-1:0] i_db_limit,
    output logic                o_sync,
    output logic                o_mismatch_c,
    output logic                o_status,
    output logic                o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DB_WIDTH-1:0]    r_cnt;
    logic                   r_status;
    logic                   r_fall;
    logic                   w_sync;

    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_lock};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // A counter above a freshly lowered limit wraps before it can match again.
    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            r_cnt    <= '0;
            r_status <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            if (w_sync == r_status) begin
                r_cnt <= '0;
            end else if (r_cnt == i_db_limit) begin
                r_status <= w_sync;
                r_cnt    <= '0;
                r_fall   <= r_status;
            end else begin
                r_cnt <= r_cnt + DB_WIDTH'(1);
            end
        end
    end

    assign o_sync       = w_sync;
    assign o_mismatch_c = w_sync ^ r_status;
    assign o_status     = r_status;
    assign o_fall       = r_fall;

endmodule

// File: rtl/lock_monitor.sv
// Lock monitor top: per-channel debouncers, settings registers, sticky
// loss flags, saturating loss counters, interrupt and readback mux.
module lock_monitor
    import lock_monitor_pkg::*;
#(
    parameter int unsigned        NUM_LOCKS   = 2,
    parameter int unsigned        SYNC_STAGES = 2,
    parameter int unsigned        DB_WIDTH    = 16,
    parameter int unsigned        CNT_WIDTH   = 8,
    parameter int unsigned        AWIDTH      = 8,
    parameter logic [AWIDTH-1:0]  SR_BASE     = AWIDTH'(64)
) (
    input  logic                 bus_clk,
    input  logic                 bus_rst,
    input  logic [NUM_LOCKS-1:0] lock_in,
    input  logic                 set_stb,
    input  logic [AWIDTH-1:0]    set_addr,
    input  logic [31:0]          set_data,
    input  logic [4:0]           rb_addr,
    output logic [31:0]          rb_data,
    output logic [NUM_LOCKS-1:0] lock_status,
    output logic [NUM_LOCKS-1:0] lock_lost,
    output logic                 irq
);

    logic [DB_WIDTH-1:0]  r_db_limit;
    logic [NUM_LOCKS-1:0] r_irq_en;
    logic [NUM_LOCKS-1:0] r_lock_lost;
    logic [CNT_WIDTH-1:0] r_loss_cnt [NUM_LOCKS];
    logic                 r_irq;
    logic [31:0]          r_rb_data;

    logic [NUM_LOCKS-1:0] w_sync;
    logic [NUM_LOCKS-1:0] w_mismatch;
    logic [NUM_LOCKS-1:0] w_status;
    logic [NUM_LOCKS-1:0] w_fall;
    logic                 w_wr_db;
    logic                 w_wr_lost;
    logic                 w_wr_cnt;
    logic                 w_wr_irq;
    logic [NUM_LOCKS-1:0] w_lost_clr;
    logic [NUM_LOCKS-1:0] w_cnt_clr;
    logic [31:0]          w_rb_next;
    logic                 w_unused_set_data;

    for (genvar i = 0; i < NUM_LOCKS; i++) begin : g_ch
        lock_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_WIDTH    (DB_WIDTH)
        ) u_db (
            .bus_clk      (bus_clk),
            .bus_rst      (bus_rst),
            .i_lock       (lock_in[i]),
            .i_db_limit   (r_db_limit),
            .o_sync       (w_sync[i]),
            .o_mismatch_c (w_mismatch[i]),
            .o_status     (w_status[i]),
            .o_fall       (w_fall[i])
        );
    end

    assign w_wr_db    = set_stb && (set_addr == SR_BASE + AWIDTH'(LM_SR_DB_LIMIT));
    assign w_wr_lost  = set_stb && (set_addr == SR_BASE + AWIDTH'(LM_SR_LOST_CLR));
    assign w_wr_cnt   = set_stb && (set_addr == SR_BASE + AWIDTH'(LM_SR_CNT_CLR));
    assign w_wr_irq   = set_stb && (set_addr == SR_BASE + AWIDTH'(LM_SR_IRQ_EN));
    assign w_lost_clr = w_wr_lost ? set_data[NUM_LOCKS-1:0] : '0;
    assign w_cnt_clr  = w_wr_cnt  ? set_data[NUM_LOCKS-1:0] : '0;

    assign w_unused_set_data = &{1'b0, set_data};

    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            r_db_limit <= '1;
            r_irq_en   <= '0;
        end else begin
            if (w_wr_db) begin
                r_db_limit <= set_data[DB_WIDTH-1:0];
            end
            if (w_wr_irq) begin
                r_irq_en <= set_data[NUM_LOCKS-1:0];
            end
        end
    end

    // A loss event beats a same-cycle clear for both flag and counter.
    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            r_lock_lost <= '0;
            r_irq       <= 1'b0;
            for (int i = 0; i < NUM_LOCKS; i++) begin
                r_loss_cnt[i] <= '0;
            end
        end else begin
            r_lock_lost <= (r_lock_lost & ~w_lost_clr) | w_fall;
            r_irq       <= |(r_lock_lost & r_irq_en);
            for (int i = 0; i < NUM_LOCKS; i++) begin
                if (w_fall[i]) begin
                    if (w_cnt_clr[i]) begin
                        r_loss_cnt[i] <= CNT_WIDTH'(1);
                    end else if (r_loss_cnt[i] != '1) begin
                        r_loss_cnt[i] <= r_loss_cnt[i] + CNT_WIDTH'(1);
                    end
                end else if (w_cnt_clr[i]) begin
                    r_loss_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        w_rb_next = LM_RB_DEFAULT;
        if (rb_addr == 5'(LM_RB_STATUS)) begin
            w_rb_next = {16'(r_lock_lost), 16'(w_status)};
        end else if (rb_addr == 5'(LM_RB_CFG)) begin
            w_rb_next = {16'(r_irq_en), 16'(r_db_limit)};
        end else if (rb_addr == 5'(LM_RB_RAW)) begin
            w_rb_next = {16'(w_sync), 16'(w_mismatch)};
        end
        for (int k = 0; k < NUM_LOCKS; k++) begin
            if (rb_addr == 5'(LM_RB_CNT_BASE + k)) begin
                w_rb_next = 32'(r_loss_cnt[k]);
            end
        end
    end

    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            r_rb_data <= '0;
        end else begin
            r_rb_data <= w_rb_next;
        end
    end

    assign rb_data     = r_rb_data;
    assign lock_status = w_status;
    assign lock_lost   = r_lock_lost;
    assign irq         = r_irq;

endmodule
